// File: rtl/exceed_detect_scheduler.sv
// Two-requester round-robin front end for the exceed-detection engine: launches a job,
// times the engine latency, captures the exceed map. Optional popcount: EXCEED_SCHED_POPCNT_EN.
module exceed_detect_scheduler #(
    parameter int INWIDTH_DELTA = 17,
    parameter int ENGINE_LAT    = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_i,
    input  logic [INWIDTH_DELTA-1:0] thres1_0_i,
    input  logic [INWIDTH_DELTA-1:0] thres1_1_i,
    input  logic [INWIDTH_DELTA-1:0] thres2_0_i,
    input  logic [INWIDTH_DELTA-1:0] thres2_1_i,
    output logic [1:0]               ack_o,
    output logic                     eng_start_o,
    output logic                     eng_sel_o,
    output logic [INWIDTH_DELTA-1:0] eng_thres1_o,
    output logic [INWIDTH_DELTA-1:0] eng_thres2_o,
    input  logic [15:0]              eng_map_i,
    output logic [1:0]               done_o,
    output logic [15:0]              map_o,
    output logic                     busy_o
`ifdef EXCEED_SCHED_POPCNT_EN
    ,
    output logic [4:0]               exceed_cnt_o
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    // LAUNCH is start+0, WAIT spans start+1..start+LAT-1 while the counter runs down to 0.
    localparam logic [5:0] CNT_LOAD = 6'(ENGINE_LAT - 2);

    logic [2:0]               state_reg, state_next;
    logic                     grant_reg;
    logic                     prio_reg;
    logic                     pick;
    logic [5:0]               cnt_reg;
    logic [INWIDTH_DELTA-1:0] thres1_reg, thres2_reg;
    logic [15:0]              map_reg;

    // prio_reg names the requester that wins a tie.
    always_comb begin
        pick = 1'b0;
        case (req_i)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = prio_reg;
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (|req_i) state_next = S_LAUNCH;
            S_LAUNCH:  state_next = S_WAIT;
            S_WAIT:    if (cnt_reg == 6'd0) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_RESP;
            S_RESP:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            grant_reg  <= 1'b0;
            prio_reg   <= 1'b0;
            cnt_reg    <= 6'd0;
            thres1_reg <= '0;
            thres2_reg <= '0;
            map_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (|req_i) begin
                        grant_reg  <= pick;
                        prio_reg   <= ~pick;
                        thres1_reg <= pick ? thres1_1_i : thres1_0_i;
                        thres2_reg <= pick ? thres2_1_i : thres2_0_i;
                    end
                end
                S_LAUNCH:  cnt_reg <= CNT_LOAD;
                S_WAIT:    if (cnt_reg != 6'd0) cnt_reg <= cnt_reg - 6'd1;
                S_CAPTURE: map_reg <= eng_map_i;
                default: ;
            endcase
        end
    end

`ifdef EXCEED_SCHED_POPCNT_EN
    logic [4:0] popcnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            popcnt_reg <= 5'd0;
        end else if (state_reg == S_CAPTURE) begin
            popcnt_reg <= 5'($countones(eng_map_i));
        end
    end

    assign exceed_cnt_o = popcnt_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ack_o[gi]  = (state_reg == S_LAUNCH) && (grant_reg == 1'(gi));
            assign done_o[gi] = (state_reg == S_RESP)   && (grant_reg == 1'(gi));
        end
    endgenerate

    assign eng_start_o  = (state_reg == S_LAUNCH);
    assign eng_sel_o    = grant_reg;
    assign eng_thres1_o = thres1_reg;
    assign eng_thres2_o = thres2_reg;
    assign map_o        = map_reg;
    assign busy_o       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_exceed_detect_scheduler.sv
// Bench for exceed_detect_scheduler: vector table plus hand sequences, with an engine stub
// and a done_o scoreboard; a second instance runs at ENGINE_LAT=2.
module tb_exceed_detect_scheduler;

    localparam int W  = 17;
    localparam int L  = 19;
    localparam int L2 = 2;

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] t10, t20, t11, t21;
        logic [15:0]  map;
        logic         sel;
    } vec_t;

    typedef struct {
        int          due;
        logic        sel;
        logic [15:0] map;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   req = 2'b00, req2 = 2'b00;
    logic [W-1:0] t10 = '0, t20 = '0, t11 = '0, t21 = '0;
    logic [15:0]  eng_map = 16'h0000, eng_map2 = 16'h0000;
    logic [15:0]  stub_map = 16'h0000, stub_map2 = 16'h0000;

    logic [1:0]   ack_o, done_o, ack2, done2;
    logic         eng_start_o, eng_sel_o, busy_o, start2, sel2, busy2;
    logic [W-1:0] eng_thres1_o, eng_thres2_o, th1_2, th2_2;
    logic [15:0]  map_o, map2;
`ifdef EXCEED_SCHED_POPCNT_EN
    logic [4:0]   exceed_cnt_o, cnt2;
`endif

    exceed_detect_scheduler #(.INWIDTH_DELTA(W), .ENGINE_LAT(L)) u_dut (
        .clk(clk), .rst(rst), .req_i(req),
        .thres1_0_i(t10), .thres1_1_i(t11), .thres2_0_i(t20), .thres2_1_i(t21),
        .ack_o(ack_o), .eng_start_o(eng_start_o), .eng_sel_o(eng_sel_o),
        .eng_thres1_o(eng_thres1_o), .eng_thres2_o(eng_thres2_o),
        .eng_map_i(eng_map), .done_o(done_o), .map_o(map_o), .busy_o(busy_o)
`ifdef EXCEED_SCHED_POPCNT_EN
        , .exceed_cnt_o(exceed_cnt_o)
`endif
    );

    exceed_detect_scheduler #(.INWIDTH_DELTA(W), .ENGINE_LAT(L2)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(req2),
        .thres1_0_i(t10), .thres1_1_i(t11), .thres2_0_i(t20), .thres2_1_i(t21),
        .ack_o(ack2), .eng_start_o(start2), .eng_sel_o(sel2),
        .eng_thres1_o(th1_2), .eng_thres2_o(th2_2),
        .eng_map_i(eng_map2), .done_o(done2), .map_o(map2), .busy_o(busy2)
`ifdef EXCEED_SCHED_POPCNT_EN
        , .exceed_cnt_o(cnt2)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine stubs: the map is valid only in the cycle exactly LAT after start, its complement otherwise.
    int cd = 0, cd2 = 0;
    always @(negedge clk) begin
        if (rst) begin
            cd = 0; eng_map = ~stub_map;
        end else if (eng_start_o) begin
            cd = L; eng_map = ~stub_map;
        end else if (cd > 1) begin
            cd--; eng_map = ~stub_map;
        end else if (cd == 1) begin
            cd = 0; eng_map = stub_map;
        end else begin
            eng_map = ~stub_map;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            cd2 = 0; eng_map2 = ~stub_map2;
        end else if (start2) begin
            cd2 = L2; eng_map2 = ~stub_map2;
        end else if (cd2 > 1) begin
            cd2--; eng_map2 = ~stub_map2;
        end else if (cd2 == 1) begin
            cd2 = 0; eng_map2 = stub_map2;
        end else begin
            eng_map2 = ~stub_map2;
        end
    end

    // Scoreboard: every done_o pops one expected completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done_o != 2'b00) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("done_cycle", cyc, e.due);
                check("done_onehot", 32'(done_o), e.sel ? 32'd2 : 32'd1);
                check("sel_at_done", 32'(eng_sel_o), 32'(e.sel));
                check("map_o", 32'(map_o), 32'(e.map));
                check("no_ack_with_done", 32'(ack_o), 32'd0);
`ifdef EXCEED_SCHED_POPCNT_EN
                check("exceed_cnt", 32'(exceed_cnt_o), 32'($countones(e.map)));
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_start"}, 32'(eng_start_o), 32'd0);
        check({tag, "_sel"}, 32'(eng_sel_o), 32'd0);
        check({tag, "_thres1"}, 32'(eng_thres1_o), 32'd0);
        check({tag, "_thres2"}, 32'(eng_thres2_o), 32'd0);
        check({tag, "_map"}, 32'(map_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
`ifdef EXCEED_SCHED_POPCNT_EN
        check({tag, "_cnt"}, 32'(exceed_cnt_o), 32'd0);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        wait_idle();
        t10 = v.t10; t20 = v.t20; t11 = v.t11; t21 = v.t21;
        stub_map = v.map;
        req = v.req;
        c = cyc;
        sbq.push_back('{c + L + 2, v.sel, v.map});
        @(negedge clk);
        check("ack", 32'(ack_o), v.sel ? 32'd2 : 32'd1);
        check("start", 32'(eng_start_o), 32'd1);
        check("sel", 32'(eng_sel_o), 32'(v.sel));
        check("thres1", 32'(eng_thres1_o), 32'(v.sel ? v.t11 : v.t10));
        check("thres2", 32'(eng_thres2_o), 32'(v.sel ? v.t21 : v.t20));
        req = 2'b00;
        $display("[TB] vec req=%b sel=%0d map=%h launched at cycle %0d", v.req, v.sel, v.map, cyc);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[7];
        int s, prev, d, n, cnt_ack, cnt_done, c;
        logic [1:0] rr_exp[3];

        vecs[0] = '{2'b01, 17'd100,     17'd50,  17'd7,       17'd9,      16'h8001, 1'b0};
        vecs[1] = '{2'b11, 17'd1,       17'd2,   17'd3,       17'd4,      16'hFFFF, 1'b1};
        vecs[2] = '{2'b11, 17'h1FFFF,   17'd0,   17'd0,       17'h1FFFF,  16'h0000, 1'b0};
        vecs[3] = '{2'b10, 17'd5,       17'd6,   17'h10000,   17'h0FFFF,  16'h1234, 1'b1};
        vecs[4] = '{2'b11, 17'd11,      17'd22,  17'd33,      17'd44,     16'hA5A5, 1'b0};
        vecs[5] = '{2'b01, 17'd9,       17'd8,   17'd7,       17'd6,      16'h0F0F, 1'b0};
        vecs[6] = '{2'b11, 17'd20,      17'd30,  17'd40,      17'd50,     16'h7FFE, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        wait_idle();

        // Both requests held from reset: grants 0,1,0 spaced LAT+3 apart
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        stub_map = 16'hC3C3;
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!eng_start_o && n < 100);
            check("rr_start_seen", 32'(eng_start_o), 32'd1);
            s = cyc;
            check("rr_ack", 32'(ack_o), 32'(rr_exp[k]));
            sbq.push_back('{s + L + 1, rr_exp[k][1], 16'hC3C3});
            if (k > 0) check("rr_spacing", s - prev, L + 3);
            prev = s;
            if (k == 2) req = 2'b00;
            $display("[TB] rr start %0d at cycle %0d ack=%b", k, s, ack_o);
        end
        wait_idle();

        // Request 1 arrives while requester 0 is in WAIT
        stub_map = 16'h0180;
        req = 2'b01; t11 = 17'd77; t21 = 17'd88;
        c = cyc;
        sbq.push_back('{c + L + 2, 1'b0, 16'h0180});
        @(negedge clk);
        check("late_ack0", 32'(ack_o), 32'd1);
        req = 2'b00;
        repeat (5) @(negedge clk);
        req = 2'b10;
        cnt_ack = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack_o != 2'b00) cnt_ack++;
        end while (done_o == 2'b00 && n < 100);
        check("late_no_early_ack", cnt_ack, 0);
        d = cyc;
        stub_map = 16'h4242;
        @(negedge clk);
        check("late_idle_busy", 32'(busy_o), 32'd0);
        check("late_idle_ack", 32'(ack_o), 32'd0);
        sbq.push_back('{cyc + L + 2, 1'b1, 16'h4242});
        @(negedge clk);
        check("late_ack1_cycle", cyc - d, 2);
        check("late_ack1", 32'(ack_o), 32'd2);
        check("late_thres1", 32'(eng_thres1_o), 32'd77);
        req = 2'b00;
        $display("[TB] late request acked at cycle %0d", cyc);
        wait_idle();

        // Reset five cycles into a job: discarded, no done, pointer back to requester 0
        stub_map = 16'hBEEF;
        req = 2'b10;
        @(negedge clk);
        check("abort_ack", 32'(ack_o), 32'd2);
        req = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        for (int k = 0; k < L + 10; k++) begin
            @(negedge clk);
            if (done_o != 2'b00) cnt_done++;
        end
        check("abort_no_done", cnt_done, 0);
        $display("[TB] abort sequence done at cycle %0d", cyc);
        run_vec('{2'b11, 17'd123, 17'd45, 17'd67, 17'd89, 16'h0001, 1'b0});
        wait_idle();

        // Short-latency instance: sample at start+2, done 4 cycles after the request
        stub_map2 = 16'h00F0;
        req2 = 2'b01;
        c = cyc;
        @(negedge clk);
        check("lat2_ack", 32'(ack2), 32'd1);
        check("lat2_start", 32'(start2), 32'd1);
        req2 = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done2 == 2'b00 && n < 20);
        check("lat2_done", 32'(done2), 32'd1);
        check("lat2_done_cycle", cyc - c, 4);
        check("lat2_map", 32'(map2), 32'h00F0);
`ifdef EXCEED_SCHED_POPCNT_EN
        check("lat2_cnt", 32'(cnt2), 32'd4);
`endif
        $display("[TB] lat2 done at cycle %0d map=%h", cyc, map2);

        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
